alu_divider: RTL and testbench

//  Iterative radix-2 restoring divider: the inverse of the ALU adder/subtractor path.

---
 rtl/alu_divider_if.sv | 35 +++
 rtl/alu_divider.sv | 175 +++++++++++++++++
 tb/tb_alu_divider.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_divider_if.sv
// alu_divider_if
// Groups the START/BUSY/DONE handshake and the operand/result buses of the
// iterative divider into one bundle.
//   start     : request, sampled only while the divider is IDLE or DONE
//   signedOp  : 1 = two's-complement operands, 0 = unsigned (sampled with start)
//   op0, op1  : dividend and divisor (sampled with start)
//   busy      : an operation is in progress
//   done      : one-cycle pulse, results valid
//   quotient  : result quotient, held until the next result
//   remainder : result remainder, held until the next result
//   div0      : last operation had a zero divisor
// The master modport is the requester (ALU side), the slave modport is the divider.
interface alu_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signedOp;
    logic [WIDTH-1:0] op0;
    logic [WIDTH-1:0] op1;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div0;

    modport master (
        output start, signedOp, op0, op1,
        input  busy, done, quotient, remainder, div0
    );

    modport slave (
        input  start, signedOp, op0, op1,
        output busy, done, quotient, remainder, div0
    );
endinterface

// File: rtl/alu_divider.sv
// alu_divider
// Iterative radix-2 restoring divider computing OP0 / OP1 one quotient bit per
// cycle, signed or unsigned. Sequence: IDLE -> LOAD -> CALC (WIDTH cycles) ->
// FIX -> DONE, with DONE -> LOAD for back-to-back requests. Results are
// registered in FIX and held until the next FIX.
// Ports:
//   clk_i  : system clock, rising edge
//   rst_i  : synchronous reset, active-high, aborts any operation in progress
//   bus    : alu_divider_if.slave carrying start/signedOp/op0/op1 in and
//            busy/done/quotient/remainder/div0 out
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    alu_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op0_q, op0_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic             signed_q, signed_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             negQuot_q, negQuot_d;
    logic             negRem_q, negRem_d;
    logic             zeroDvs_q, zeroDvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remOut_q, remOut_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH:0]   trial;

    // Next-state and datapath logic. The raw operands are captured on the
    // accepting edge so that DIV0 can hand back OP0 exactly as given. The
    // partial remainder never has its MSB set before a shift (it is always
    // smaller than the bits of the dividend consumed so far), so dropping
    // rem[WIDTH-1] in the shift loses nothing. The extra top bit of the trial
    // subtraction is the borrow that decides the quotient bit. A zero divisor
    // runs through the same number of cycles so the latency is
    // data-independent, and its garbage result is replaced in FIX.
    always_comb begin
        state_d   = state_q;
        op0_d     = op0_q;
        op1_d     = op1_q;
        signed_d  = signed_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        negQuot_d = negQuot_q;
        negRem_d  = negRem_q;
        zeroDvs_d = zeroDvs_q;
        cnt_d     = cnt_q;
        quot_d    = quot_q;
        remOut_d  = remOut_q;
        div0_d    = div0_q;

        shifted = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
        trial   = {1'b0, shifted} - {1'b0, dvs_q};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = LOAD;
                    op0_d    = bus.op0;
                    op1_d    = bus.op1;
                    signed_d = bus.signedOp;
                end
            end
            LOAD: begin
                dvd_d     = (signed_q && op0_q[WIDTH-1]) ? -op0_q : op0_q;
                dvs_d     = (signed_q && op1_q[WIDTH-1]) ? -op1_q : op1_q;
                negQuot_d = signed_q && (op0_q[WIDTH-1] ^ op1_q[WIDTH-1]);
                negRem_d  = signed_q && op0_q[WIDTH-1];
                zeroDvs_d = (op1_q == '0);
                rem_d     = '0;
                cnt_d     = CW'(WIDTH - 1);
                state_d   = CALC;
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted;
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                if (zeroDvs_q) begin
                    quot_d   = '1;
                    remOut_d = op0_q;
                end else begin
                    quot_d   = negQuot_q ? -dvd_q : dvd_q;
                    remOut_d = negRem_q ? -rem_q : rem_q;
                end
                div0_d  = zeroDvs_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d  = LOAD;
                    op0_d    = bus.op0;
                    op1_d    = bus.op1;
                    signed_d = bus.signedOp;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset has priority over everything and
    // clears the visible results as well, so an aborted operation leaves no
    // trace and never reaches DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            op0_q     <= '0;
            op1_q     <= '0;
            signed_q  <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
            zeroDvs_q <= 1'b0;
            cnt_q     <= '0;
            quot_q    <= '0;
            remOut_q  <= '0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op0_q     <= op0_d;
            op1_q     <= op1_d;
            signed_q  <= signed_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            negQuot_q <= negQuot_d;
            negRem_q  <= negRem_d;
            zeroDvs_q <= zeroDvs_d;
            cnt_q     <= cnt_d;
            quot_q    <= quot_d;
            remOut_q  <= remOut_d;
            div0_q    <= div0_d;
        end
    end

    // Handshake flags decode straight from the state register, so they are
    // glitch-free and DONE lasts exactly the single DONE cycle.
    assign bus.busy      = (state_q == LOAD) || (state_q == CALC) || (state_q == FIX);
    assign bus.done      = (state_q == DONE);
    assign bus.quotient  = quot_q;
    assign bus.remainder = remOut_q;
    assign bus.div0      = div0_q;
endmodule

// File: tb/tb_alu_divider.sv
// tb_alu_divider
// Self-checking bench for alu_divider (WIDTH = 32): a table of directed
// vectors, hand-written control sequences (ignored START, reset abort,
// back-to-back issue) and randomized operands checked against a plain
// arithmetic reference model.
module tb_alu_divider;
    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] op0;
        logic [WIDTH-1:0] op1;
        logic             sgn;
        logic [WIDTH-1:0] expQ;
        logic [WIDTH-1:0] expR;
        logic             expZ;
    } vector_t;

    logic    clk;
    logic    rst;
    int      nChecks;
    int      nFails;
    vector_t vecs[9];

    alu_divider_if #(.WIDTH(WIDTH)) bus ();

    alu_divider #(.WIDTH(WIDTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with the expected one and keep the tallies.
    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference division straight from the arithmetic definition: a zero
    // divisor gives all-ones and the dividend, otherwise SV's own truncating
    // division on wide signed or unsigned values.
    task automatic refDiv(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                          output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r, output logic z);
        longint sa, sb, q64, r64;
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            q64 = sa / sb;
            r64 = sa % sb;
            q = q64[WIDTH-1:0];
            r = r64[WIDTH-1:0];
            z = 1'b0;
        end
    endtask

    // Issue one request: START is raised at a falling edge, accepted at the
    // following rising edge, and dropped at the next falling edge (LOAD cycle).
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op0      = a;
        bus.op1      = b;
        bus.signedOp = s;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Sample at falling edges until DONE, counting edges since the accepting
    // edge and watching that BUSY never drops before the result arrives.
    task automatic waitDone(input int lat0, output int lat, output logic busyOk, output logic seen);
        lat    = lat0;
        busyOk = 1'b1;
        seen   = 1'b0;
        while (!seen && lat < lat0 + 200) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (!bus.busy) busyOk = 1'b0;
                @(negedge clk);
                lat++;
            end
        end
    endtask

    // Full single operation with every observable checked, including the
    // fixed latency and that results stay put after the DONE pulse.
    task automatic runOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                         input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er, input logic ez,
                         input string tag);
        int   lat;
        logic busyOk, seen;
        applyStimulus(a, b, s);
        waitDone(0, lat, busyOk, seen);
        checkOutput({tag, " done seen"}, 32'(seen), 32'd1);
        checkOutput({tag, " latency"}, 32'(lat), 32'(WIDTH + 2));
        checkOutput({tag, " busy during op"}, 32'(busyOk), 32'd1);
        checkOutput({tag, " busy at done"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, " quotient"}, bus.quotient, eq);
        checkOutput({tag, " remainder"}, bus.remainder, er);
        checkOutput({tag, " div0"}, 32'(bus.div0), 32'(ez));
        @(negedge clk);
        checkOutput({tag, " done one cycle"}, 32'(bus.done), 32'd0);
        checkOutput({tag, " quotient held"}, bus.quotient, eq);
    endtask

    // Global time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   lat, doneCount, firstDone, secondDone;
        logic busyOk, seen, holdOk;
        logic [WIDTH-1:0] a, b, eq, er;
        logic s, ez;

        nChecks = 0;
        nFails  = 0;

        vecs[0] = '{32'd100,       32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
        vecs[1] = '{32'hFFFFFFF9,  32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
        vecs[2] = '{32'hFFFFFFF9,  32'd2,          1'b0, 32'h7FFFFFFC,   32'd1,          1'b0};
        vecs[3] = '{32'd5,         32'd0,          1'b1, 32'hFFFFFFFF,   32'd5,          1'b1};
        vecs[4] = '{32'h80000000,  32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0};
        vecs[5] = '{32'h80000000,  32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   1'b0};
        vecs[6] = '{32'd7,         32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0};
        vecs[7] = '{32'd5,         32'd0,          1'b0, 32'hFFFFFFFF,   32'd5,          1'b1};
        vecs[8] = '{32'hFFFFFFFB,  32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1};

        bus.start    = 1'b0;
        bus.signedOp = 1'b0;
        bus.op0      = '0;
        bus.op1      = '0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset quotient", bus.quotient, 32'd0);
        checkOutput("reset remainder", bus.remainder, 32'd0);
        checkOutput("reset div0", 32'(bus.div0), 32'd0);
        rst = 1'b0;

        $display("[TB] directed vectors");
        for (int i = 0; i < 9; i++) begin
            runOp(vecs[i].op0, vecs[i].op1, vecs[i].sgn, vecs[i].expQ, vecs[i].expR, vecs[i].expZ,
                  $sformatf("vec%0d", i));
        end

        $display("[TB] START during CALC is ignored");
        applyStimulus(32'd100, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.op0   = 32'd9;
        bus.op1   = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(6, lat, busyOk, seen);
        checkOutput("ignore done seen", 32'(seen), 32'd1);
        checkOutput("ignore latency", 32'(lat), 32'(WIDTH + 2));
        checkOutput("ignore quotient", bus.quotient, 32'd14);
        checkOutput("ignore remainder", bus.remainder, 32'd2);
        doneCount = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) doneCount++;
        end
        checkOutput("ignore no second done", 32'(doneCount), 32'd0);

        $display("[TB] reset mid-operation");
        applyStimulus(32'd9, 32'd3, 1'b1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort busy", 32'(bus.busy), 32'd0);
        checkOutput("abort quotient", bus.quotient, 32'd0);
        checkOutput("abort remainder", bus.remainder, 32'd0);
        doneCount = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.done) doneCount++;
        end
        checkOutput("abort no done", 32'(doneCount), 32'd0);

        $display("[TB] back-to-back issue");
        @(negedge clk);
        bus.start    = 1'b1;
        bus.signedOp = 1'b0;
        bus.op0      = 32'd100;
        bus.op1      = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.op0    = 32'd9;
        bus.op1    = 32'd3;
        lat        = 0;
        firstDone  = -1;
        secondDone = -1;
        holdOk     = 1'b1;
        while (secondDone < 0 && lat < 200) begin
            if (bus.done && firstDone < 0) begin
                firstDone = lat;
                checkOutput("b2b first quotient", bus.quotient, 32'd14);
                checkOutput("b2b first remainder", bus.remainder, 32'd2);
            end else if (bus.done) begin
                secondDone = lat;
            end else if (firstDone >= 0) begin
                bus.start = 1'b0;
                if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2) holdOk = 1'b0;
            end
            if (secondDone < 0) begin
                @(negedge clk);
                lat++;
            end
        end
        bus.start = 1'b0;
        checkOutput("b2b first done latency", 32'(firstDone), 32'(WIDTH + 2));
        checkOutput("b2b done spacing", 32'(secondDone - firstDone), 32'(WIDTH + 3));
        checkOutput("b2b hold until second fix", 32'(holdOk), 32'd1);
        checkOutput("b2b second quotient", bus.quotient, 32'd3);
        checkOutput("b2b second remainder", bus.remainder, 32'd0);
        @(negedge clk);

        $display("[TB] randomized operands");
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 255));
                2: b = -32'($urandom_range(1, 16));
                default: b = (i % 8 == 0) ? 32'd0 : ($urandom & 32'h0000FFFF);
            endcase
            refDiv(a, b, s, eq, er, ez);
            runOp(a, b, s, eq, er, ez, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
